rom_access_arbiter: RTL
=======================

Name: rom_access_arbiter

Overview:
- Sequences the `rom` block, which has ports addr[3:0], CS and out[15:0] and updates out on the falling edge of CS.
- Shares that single ROM between two requesters using round-robin arbitration.
- Generates the CS high-then-low strobe, latches the returned word, and returns it to the granted requester with a one-cycle ack.
- Sits between the `rom` instance and the two consumer blocks. It is the only driver of rom addr/CS.

Parameters:
- ADDR_W, 4: ROM address width.
- DATA_W, 16: ROM word width.
- SETUP_CYCLES, 1: cycles rom_addr is held with rom_cs high before the strobe. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 read request, level, held until ack0.
- addr0  input  ADDR_W  requester 0 address, sampled at grant.
- req1  input  1  requester 1 read request, level, held until ack1.
- addr1  input  ADDR_W  requester 1 address, sampled at grant.
- ack0  output  1  one-cycle pulse: rdata valid for requester 0.
- ack1  output  1  one-cycle pulse: rdata valid for requester 1.
- rdata  output  DATA_W  last captured ROM word; holds until next capture.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  1  requester owning the current or last access.
- rom_addr  output  ADDR_W  to rom addr.
- rom_cs  output  1  to rom CS; the falling edge triggers the ROM read.
- rom_out  input  DATA_W  from rom out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rom_cs=1, rom_addr=0, rdata=0.
  - ack0=ack1=0, busy=0, grant_id=0, last_grant=1 (requester 0 wins the first tie).
  - Any in-flight access is abandoned with no ack.
- All outputs are registered.
- FSM states: IDLE, SETUP, STROBE, CAPTURE.
- IDLE:
  - rom_cs=1. Requests are sampled only in IDLE.
  - Only req0 high → grant 0. Only req1 high → grant 1.
  - Both high → grant the requester not equal to last_grant.
  - On grant: latch the winner's address into rom_addr, set grant_id and last_grant, load setup counter with SETUP_CYCLES-1, go to SETUP.
- SETUP: rom_cs=1, rom_addr stable. Counter decrements each cycle; at 0 go to STROBE.
- STROBE: rom_cs driven 0 (falling edge at entry), rom_addr stable. Next cycle go to CAPTURE.
- CAPTURE:
  - rom_cs returns to 1; rdata <= rom_out.
  - ack[grant_id] asserts for exactly this one cycle.
  - Next cycle go to IDLE.
- Latency: req sampled at edge E0 → ack and rdata valid after edge E0+SETUP_CYCLES+2.
  - Default: 3 cycles.
  - Throughput: one access per SETUP_CYCLES+3 cycles.
- Handshake:
  - A requester must drop req in the cycle after it sees ack.
  - A req still high when IDLE is next evaluated is a new request.
- addr0/addr1 changes after grant are ignored until the next grant.
- A request from the non-granted requester during an access waits; it is never dropped.
- Both requesters held high continuously → strict alternation 0,1,0,1...
- rom_cs never falls outside STROBE. Exactly one falling edge per access.
- rom_addr does not change while rom_cs=0.
- ack0 and ack1 are never high simultaneously.

Test Plan:
- Single read, SETUP_CYCLES=1: req0=1 with addr0=3, rom holding ROM[3]=16'h0AC1 → rom_cs high 1 cycle then low 1 cycle; ack0 pulses once 3 cycles after sampling; rdata=16'h0AC1; ack1 stays 0.
- Tie: req0 (addr0=2) and req1 (addr1=9) rise together → ack0 with rdata=16'h1801 first, then ack1 with rdata=16'h3801; exactly 2 falling edges on rom_cs.
- Fairness: req0 and req1 held high for 8 accesses with addr0=0, addr1=15 → grant_id sequence 0,1,0,1,...; rdata alternates 16'h5601/16'h5401.
- Reset mid-access: assert rst_n=0 during STROBE → outputs go to reset values immediately, no ack; after release, a pending req1 is served first when req0 is low.
- Latency param SETUP_CYCLES=3: req1 with addr1=8 → rom_cs high 3 cycles before the strobe; ack1 5 cycles after sampling; rdata=16'h4801.
- Address hold: change addr0 from 4 to 5 while in SETUP → rom_addr stays 4; rdata=16'h0521.

Source files
------------

// File: rtl/rom_access_arbiter.sv
// rtl/rom_access_arbiter.sv - round-robin arbiter sequencing one CS-strobed ROM for two requesters
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/addr0          requester 0 level request and address (sampled at grant)
//   req1/addr1          requester 1 level request and address (sampled at grant)
//   ack0/ack1           one-cycle pulse, rdata valid for that requester
//   rdata               last captured ROM word, held until the next capture
//   busy                high whenever an access is in progress
//   grant_id            requester owning the current or last access
//   rom_addr/rom_cs     drive the ROM; the falling edge of rom_cs launches the read
//   rom_out             ROM data return
module rom_access_arbiter #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 16,
  parameter int SETUP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              grant_id,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  input  logic [DATA_W-1:0] rom_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_CAPTURE
  } state_t;

  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_last_grant;

  logic w_any_req;
  logic w_pick1;

  // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
  assign w_any_req = req0 | req1;
  assign w_pick1   = req1 & (~req0 | ~r_last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      rom_cs       <= 1'b1;
      rom_addr     <= '0;
      rdata        <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= 1'b0;
    end else begin
      // Acks are single-cycle; only the CAPTURE exit raises one.
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          rom_cs <= 1'b1;
          if (w_any_req) begin
            grant_id     <= w_pick1;
            r_last_grant <= w_pick1;
            rom_addr     <= w_pick1 ? addr1 : addr0;
            r_cnt        <= SETUP_LOAD;
            busy         <= 1'b1;
            r_state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == 4'd0) begin
            // Falling edge of rom_cs lands at STROBE entry.
            rom_cs  <= 1'b0;
            r_state <= ST_STROBE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          rom_cs  <= 1'b1;
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // ROM output settled at the strobe; capture it and hand it back.
          rdata   <= rom_out;
          ack0    <= ~grant_id;
          ack1    <= grant_id;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          rom_cs  <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
